// File: rtl/stage_sequencer_pkg.sv
// Shared definitions for the inference stage sequencer.
//   - One-hot stage codes driven onto compute_stage
//   - Per-stage loop bounds (inclusive maxima) and loop nesting order
//   - Pipeline drain length and FSM state encoding
package stage_sequencer_pkg;

  localparam logic [8:0] CODE_CONV1    = 9'h040;
  localparam logic [8:0] CODE_MAXPOOL  = 9'h020;
  localparam logic [8:0] CODE_CONV2    = 9'h010;
  localparam logic [8:0] CODE_CONV3    = 9'h008;
  localparam logic [8:0] CODE_GMAXPOOL = 9'h004;
  localparam logic [8:0] CODE_FC1      = 9'h002;
  localparam logic [8:0] CODE_FC2      = 9'h001;

  localparam int         PIPE_DRAIN = 8;
  localparam logic [2:0] DRAIN_LAST = 3'(PIPE_DRAIN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Stages in execution order; the sequencer steps through them with +1.
  typedef enum logic [2:0] {
    STG_CONV1,
    STG_MAXPOOL,
    STG_CONV2,
    STG_CONV3,
    STG_GMAXPOOL,
    STG_FC1,
    STG_FC2
  } stage_t;

  // Loop nesting, listed innermost first.
  typedef enum logic [1:0] {
    NEST_HDW,
    NEST_DW,
    NEST_WD
  } nest_t;

  typedef struct packed {
    logic [3:0] max_h;
    logic [4:0] max_d;
    logic [8:0] max_w;
    nest_t      nest;
  } bounds_t;

  function automatic logic [8:0] stage_code(input stage_t stage);
    logic [8:0] code;
    case (stage)
      STG_CONV1:    code = CODE_CONV1;
      STG_MAXPOOL:  code = CODE_MAXPOOL;
      STG_CONV2:    code = CODE_CONV2;
      STG_CONV3:    code = CODE_CONV3;
      STG_GMAXPOOL: code = CODE_GMAXPOOL;
      STG_FC1:      code = CODE_FC1;
      STG_FC2:      code = CODE_FC2;
      default:      code = 9'h000;
    endcase
    return code;
  endfunction

  function automatic bounds_t stage_bounds(input stage_t stage);
    bounds_t b;
    b.max_h = 4'd0;
    b.max_d = 5'd0;
    b.max_w = 9'd0;
    b.nest  = NEST_HDW;
    case (stage)
      STG_CONV1:    begin b.max_h = 4'd0;  b.max_d = 5'd7;  b.max_w = 9'd179; b.nest = NEST_HDW; end
      STG_MAXPOOL:  begin b.max_h = 4'd0;  b.max_d = 5'd7;  b.max_w = 9'd89;  b.nest = NEST_DW;  end
      STG_CONV2:    begin b.max_h = 4'd7;  b.max_d = 5'd15; b.max_w = 9'd89;  b.nest = NEST_HDW; end
      STG_CONV3:    begin b.max_h = 4'd15; b.max_d = 5'd31; b.max_w = 9'd89;  b.nest = NEST_HDW; end
      STG_GMAXPOOL: begin b.max_h = 4'd0;  b.max_d = 5'd31; b.max_w = 9'd89;  b.nest = NEST_WD;  end
      STG_FC1:      begin b.max_h = 4'd0;  b.max_d = 5'd15; b.max_w = 9'd6;   b.nest = NEST_WD;  end
      STG_FC2:      begin b.max_h = 4'd0;  b.max_d = 5'd0;  b.max_w = 9'd4;   b.nest = NEST_WD;  end
      default:      begin b.max_h = 4'd0;  b.max_d = 5'd0;  b.max_w = 9'd0;   b.nest = NEST_HDW; end
    endcase
    return b;
  endfunction

endpackage

// File: rtl/stage_sequencer_loop_counter3.sv
// Nested H/D/W iteration counter with selectable nesting order.
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   clear                return all counters to zero (wins over enable)
//   enable               advance one iteration
//   max_h/max_d/max_w    inclusive maxima of the three loops
//   nest                 nesting order, innermost loop first
//   h, d, w              current iteration
//   last                 current iteration is the final one of the stage
module loop_counter3
  import stage_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] max_h,
  input  logic [4:0] max_d,
  input  logic [8:0] max_w,
  input  nest_t      nest,
  output logic [3:0] h,
  output logic [4:0] d,
  output logic [8:0] w,
  output logic       last
);

  logic h_top, d_top, w_top;

  assign h_top = (h == max_h);
  assign d_top = (d == max_d);
  assign w_top = (w == max_w);
  assign last  = h_top && d_top && w_top;

  // Loops not named in the nesting order have a maximum of zero, so they
  // simply stay at zero for that stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      d <= '0;
      w <= '0;
    end else if (clear) begin
      h <= '0;
      d <= '0;
      w <= '0;
    end else if (enable) begin
      case (nest)
        NEST_DW: begin
          if (!d_top) begin
            d <= d + 5'd1;
          end else begin
            d <= '0;
            w <= w_top ? 9'd0 : w + 9'd1;
          end
        end
        NEST_WD: begin
          if (!w_top) begin
            w <= w + 9'd1;
          end else begin
            w <= '0;
            d <= d_top ? 5'd0 : d + 5'd1;
          end
        end
        default: begin
          if (!h_top) begin
            h <= h + 4'd1;
          end else begin
            h <= '0;
            if (!d_top) begin
              d <= d + 5'd1;
            end else begin
              d <= '0;
              w <= w_top ? 9'd0 : w + 9'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/stage_sequencer.sv
// Inference stage sequencer: walks CONV1..FC2, issuing one (stage, H, D, W)
// iteration per cycle, with a fixed pipeline drain between stages.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   start           one-cycle run request, honoured only while idle
//   stall           downstream hold; freezes iteration progress while high
//   compute_stage   one-hot stage code of the issued iteration, 0 = bubble
//   height/depth/width  loop indices of the issued iteration
//   busy            high from first issue through final drain bubble
//   done            one-cycle pulse after the final drain bubble
module stage_sequencer
  import stage_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stall,
  output logic [8:0] compute_stage,
  output logic [3:0] height,
  output logic [4:0] depth,
  output logic [8:0] width,
  output logic       busy,
  output logic       done
);

  state_t     state, state_nxt;
  stage_t     stage, stage_nxt;
  logic [2:0] drain_cnt, drain_cnt_nxt;

  logic [8:0] compute_stage_nxt;
  logic [3:0] height_nxt;
  logic [4:0] depth_nxt;
  logic [8:0] width_nxt;
  logic       busy_nxt, done_nxt;

  logic       issue, cnt_en, cnt_clr, cnt_last;
  logic [3:0] cnt_h;
  logic [4:0] cnt_d;
  logic [8:0] cnt_w;
  bounds_t    bounds;

  assign bounds = stage_bounds(stage);

  loop_counter3 u_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clr),
    .enable (cnt_en),
    .max_h  (bounds.max_h),
    .max_d  (bounds.max_d),
    .max_w  (bounds.max_w),
    .nest   (bounds.nest),
    .h      (cnt_h),
    .d      (cnt_d),
    .w      (cnt_w),
    .last   (cnt_last)
  );

  // State and all outputs are registered; nothing reaches a port
  // combinationally from start or stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      stage         <= STG_CONV1;
      drain_cnt     <= '0;
      compute_stage <= '0;
      height        <= '0;
      depth         <= '0;
      width         <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nxt;
      stage         <= stage_nxt;
      drain_cnt     <= drain_cnt_nxt;
      compute_stage <= compute_stage_nxt;
      height        <= height_nxt;
      depth         <= depth_nxt;
      width         <= width_nxt;
      busy          <= busy_nxt;
      done          <= done_nxt;
    end
  end

  // The start cycle itself issues CONV1 (0,0,0) so the first iteration
  // appears on the edge that samples start. Index outputs hold their last
  // issued value through stall and drain bubbles.
  always_comb begin
    state_nxt         = state;
    stage_nxt         = stage;
    drain_cnt_nxt     = drain_cnt;
    compute_stage_nxt = '0;
    height_nxt        = height;
    depth_nxt         = depth;
    width_nxt         = width;
    busy_nxt          = 1'b0;
    done_nxt          = 1'b0;
    issue             = 1'b0;
    cnt_en            = 1'b0;
    cnt_clr           = 1'b0;

    case (state)
      ST_IDLE: begin
        stage_nxt  = STG_CONV1;
        height_nxt = '0;
        depth_nxt  = '0;
        width_nxt  = '0;
        cnt_clr    = 1'b1;
        if (start) begin
          cnt_clr   = 1'b0;
          issue     = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy_nxt = 1'b1;
        issue    = !stall;
      end
      ST_DRAIN: begin
        busy_nxt = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          drain_cnt_nxt = '0;
          if (stage == STG_FC2) begin
            state_nxt = ST_DONE;
          end else begin
            stage_nxt = stage_t'(stage + 3'd1);
            state_nxt = ST_RUN;
          end
        end else begin
          drain_cnt_nxt = drain_cnt + 3'd1;
        end
      end
      ST_DONE: begin
        done_nxt   = 1'b1;
        height_nxt = '0;
        depth_nxt  = '0;
        width_nxt  = '0;
        stage_nxt  = STG_CONV1;
        state_nxt  = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    // The final iteration of a stage clears the counter so the next stage
    // begins at (0,0,0) once the drain completes.
    if (issue) begin
      compute_stage_nxt = stage_code(stage);
      height_nxt        = cnt_h;
      depth_nxt         = cnt_d;
      width_nxt         = cnt_w;
      if (cnt_last) begin
        cnt_clr   = 1'b1;
        state_nxt = ST_DRAIN;
      end else begin
        cnt_en = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer. A reference model walks a global
// iteration index through the stage table using division/modulo, inserting
// stall bubbles and 8-cycle drains, and predicts every output cycle.
module tb_stage_sequencer;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic [8:0] compute_stage;
  logic [3:0] height;
  logic [4:0] depth;
  logic [8:0] width;
  logic       busy;
  logic       done;

  stage_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stall         (stall),
    .compute_stage (compute_stage),
    .height        (height),
    .depth         (depth),
    .width         (width),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  localparam int DRAIN_LEN = 8;

  logic [8:0] code_tab  [7] = '{9'h040, 9'h020, 9'h010, 9'h008, 9'h004, 9'h002, 9'h001};
  int         max_h     [7] = '{0, 0, 7, 15, 0, 0, 0};
  int         max_d     [7] = '{7, 7, 15, 31, 31, 15, 0};
  int         max_w     [7] = '{179, 89, 89, 89, 89, 6, 4};
  // 0: H fastest, then D, then W; 1: D fastest, then W; 2: W fastest, then D
  int         order     [7] = '{0, 1, 0, 0, 2, 2, 2};
  int         exp_count [7] = '{1440, 720, 11520, 46080, 2880, 112, 5};

  int total = 0;
  int bad   = 0;

  // model: 0 idle, 1 active, 2 done pulse due
  int mode         = 0;
  int next_idx     = 0;
  int bubbles_left = 0;
  int last_h       = 0;
  int last_d       = 0;
  int last_w       = 0;

  int busy_cycles = 0;
  int done_seen   = 0;
  int stage_issues [7];

  function automatic int stage_len(input int s);
    return (max_h[s] + 1) * (max_d[s] + 1) * (max_w[s] + 1);
  endfunction

  function automatic int offset_of(input int s);
    int acc = 0;
    for (int k = 0; k < s; k++) acc += stage_len(k);
    return acc;
  endfunction

  function automatic void decode(input int idx, output int s, output int h,
                                 output int d, output int w, output bit lst);
    int rem = idx;
    s = 0;
    while (s < 6 && rem >= stage_len(s)) begin
      rem -= stage_len(s);
      s++;
    end
    lst = (rem == stage_len(s) - 1);
    case (order[s])
      0: begin
        h = rem % (max_h[s] + 1);
        d = (rem / (max_h[s] + 1)) % (max_d[s] + 1);
        w = rem / ((max_h[s] + 1) * (max_d[s] + 1));
      end
      1: begin
        h = 0;
        d = rem % (max_d[s] + 1);
        w = rem / (max_d[s] + 1);
      end
      default: begin
        h = 0;
        w = rem % (max_w[s] + 1);
        d = rem / (max_w[s] + 1);
      end
    endcase
  endfunction

  function automatic logic [31:0] obs_all();
    return {3'b0, compute_stage, height, depth, width, busy, done};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, observed, expected);
    end
  endtask

  task automatic clearStats();
    busy_cycles = 0;
    done_seen   = 0;
    for (int s = 0; s < 7; s++) stage_issues[s] = 0;
  endtask

  task automatic expectIssue();
    int s, h, d, w;
    bit lst;
    decode(next_idx, s, h, d, w, lst);
    checkOutput("issue", obs_all(), {3'b0, code_tab[s], 4'(h), 5'(d), 9'(w), 1'b1, 1'b0});
    last_h = h;
    last_d = d;
    last_w = w;
    next_idx++;
    mode = 1;
    if (lst) bubbles_left = DRAIN_LEN;
  endtask

  // Drive one cycle of inputs, then check the registered response at negedge.
  task automatic applyStimulus(input bit st, input bit sl);
    start = st;
    stall = sl;
    @(posedge clk);
    @(negedge clk);
    if (busy) busy_cycles++;
    if (done) done_seen++;
    for (int s = 0; s < 7; s++) if (compute_stage == code_tab[s]) stage_issues[s]++;
    case (mode)
      0: begin
        if (st) begin
          next_idx = 0;
          expectIssue();
        end else begin
          checkOutput("idle", obs_all(), 32'd0);
        end
      end
      1: begin
        if (bubbles_left > 0) begin
          checkOutput("drain", {21'b0, compute_stage, busy, done}, {21'b0, 9'h000, 1'b1, 1'b0});
          bubbles_left--;
          if (bubbles_left == 0 && next_idx == offset_of(7)) mode = 2;
        end else if (sl) begin
          checkOutput("stall", obs_all(),
                      {3'b0, 9'h000, 4'(last_h), 5'(last_d), 9'(last_w), 1'b1, 1'b0});
        end else begin
          expectIssue();
        end
      end
      default: begin
        checkOutput("done", obs_all(), {3'b0, 9'h000, 4'd0, 5'd0, 9'd0, 1'b0, 1'b1});
        mode = 0;
      end
    endcase
  endtask

  // Assert reset between clock edges; outputs must clear without an edge.
  task automatic applyReset(input int cycles);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset", obs_all(), 32'd0);
    repeat (cycles) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      checkOutput("in_reset", obs_all(), 32'd0);
    end
    start        = 1'b0;
    stall        = 1'b0;
    rst_n        = 1'b1;
    mode         = 0;
    next_idx     = 0;
    bubbles_left = 0;
  endtask

  initial begin
    int guard;
    int stall_left;
    int target;
    int stop_idx;
    bit st, sl;

    @(negedge clk);
    applyReset(3);
    repeat (3) applyStimulus(1'b0, 1'($urandom_range(0, 1)));

    // Full run: no stall except three cycles just before CONV3 (6,2,10),
    // random ignored start pulses throughout.
    $display("[TB] full run");
    clearStats();
    target     = offset_of(3) + 6 + 16 * (2 + 32 * 10);
    stall_left = 3;
    applyStimulus(1'b1, 1'b0);
    guard = 0;
    while (mode != 0 && guard < 70000) begin
      sl = (mode == 1 && bubbles_left == 0 && next_idx == target && stall_left > 0);
      if (sl) stall_left--;
      st = ($urandom_range(0, 99) < 2);
      applyStimulus(st, sl);
      guard++;
    end
    checkOutput("busy_span", busy_cycles, 62813 + 3);
    checkOutput("done_pulses", done_seen, 1);
    for (int s = 0; s < 7; s++) checkOutput("stage_issue_count", stage_issues[s], exp_count[s]);
    repeat (2) applyStimulus(1'b0, 1'b0);

    // Random stalls, start together with stall, reset mid-MAXPOOL.
    $display("[TB] random stall run with reset");
    clearStats();
    applyStimulus(1'b1, 1'b1);
    stop_idx = offset_of(1) + 40 + int'($urandom_range(0, 500));
    guard = 0;
    while (next_idx < stop_idx && guard < 5000) begin
      applyStimulus($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 25);
      guard++;
    end
    checkOutput("reached_maxpool", {23'b0, compute_stage} & {23'b0, 9'h020} | {31'b0, stall}, 32'h020 | {31'b0, stall});
    applyReset(4);
    checkOutput("no_done_after_abort", done_seen, 0);
    repeat (3) applyStimulus(1'b0, 1'($urandom_range(0, 1)));
    applyStimulus(1'b1, 1'b0);
    repeat (300) applyStimulus($urandom_range(0, 99) < 5, $urandom_range(0, 99) < 25);
    applyReset(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 Clk  input  1  single clock; all state updates on rising edge.
REQ-002 Rst_n  input  1  asynchronous, active-low reset.
REQ-003 Start  input  1  one-cycle request to run one full inference; sampled only in IDLE.
REQ-004 Stall  input  1  downstream hold request; freezes iteration progress while high.
REQ-005 Compute_stage  output reg  9  one-hot stage code for the current issue cycle; 0 = bubble.
REQ-006 Height  output reg  4  input-channel index (conv accumulation loop).
REQ-007 Depth  output reg  5  output-channel / neuron index.
REQ-008 Width  output reg  9  spatial position / FC input-chunk index.
REQ-009 Busy  output reg  1  high from the first issue cycle through the final drain cycle.
REQ-010 Done  output reg  1  one-cycle pulse after the final drain cycle.

Function
REQ-011 Stage codes, in order: CONV1=9'h040, MAXPOOL=9'h020, CONV2=9'h010, CONV3=9'h008, GMAXPOOL=9'h004, FC1=9'h002, FC2=9'h001.
REQ-012 Loop bounds (inclusive maxima, H/D/W): CONV1 0/7/179, MAXPOOL 0/7/89, CONV2 7/15/89, CONV3 15/31/89, GMAXPOOL 0/31/89, FC1 0/15/6, FC2 0/0/4.
REQ-013 Loop nesting, conv stages (CONV1–CONV3): Height innermost, then Depth, then Width outermost.
REQ-014 Loop nesting, MAXPOOL: Depth innermost, Width outer.
REQ-015 Loop nesting, GMAXPOOL and FC stages: Width innermost, Depth outer.
REQ-016 States: IDLE, RUN, DRAIN, DONE.
REQ-017 IDLE: outputs zero; Start=1 -> RUN with all counters 0 and stage=CONV1.
REQ-018 RUN, Stall=0: emit the current (stage, H, D, W) as registered outputs, then advance the innermost counter with carry per REQ-013–REQ-015.
REQ-019 RUN, last iteration of a stage issued -> DRAIN.
REQ-020 RUN, Stall=1: Compute_stage=0, H/D/W hold their last values, counters frozen, no iteration skipped or repeated.
REQ-021 DRAIN: Compute_stage=0 for exactly PIPE_DRAIN=8 cycles, independent of Stall.
REQ-022 DRAIN exit: after the 8th cycle, if the stage was not FC2 -> RUN with the next stage and counters 0.
REQ-023 DRAIN exit after FC2 -> DONE.
REQ-024 DONE: Done=1 and Busy=0 for one cycle -> IDLE.
REQ-025 Start outside IDLE is ignored; Start in the same cycle as a Stall in IDLE still starts.
REQ-026 Latency: the first CONV1 issue is registered on the edge after Start is sampled.
REQ-027 No iteration outside the REQ-012 bounds is ever emitted; counters never wrap mid-stage.
REQ-028 Issue count per run is fixed at 62757; with drains, Busy spans 62813 cycles when Stall=0.

Reset
REQ-029 Rst_n low forces IDLE immediately (asynchronous); Compute_stage, Height, Depth, Width, Busy and Done become 0.
REQ-030 Counters and drain count also become 0 on reset; reset mid-run aborts with no Done pulse.
REQ-031 After Rst_n releases, the block waits for a new Start.

Structure
REQ-032 Shared package holds the stage one-hot constants, the per-stage loop-bound table, PIPE_DRAIN and the state encoding.
REQ-033 One sub-module is natural: loop_counter3, a nested H/D/W counter with enable, bounds inputs, selectable nesting order, and a last-iteration flag.
REQ-034 All outputs are registered; no combinational path from Start or Stall to any output.

Verification
REQ-035 Scenario 1, first issue: Start pulse with Stall=0 -> next cycle Compute_stage=9'h040, H=0, D=0, W=0, Busy=1; then D steps 1..7 before W becomes 1.
REQ-036 Scenario 2, full run: Start with Stall=0 throughout -> Done one cycle after 62813 Busy cycles; per-stage issue counts are 1440/720/11520/46080/2880/112/5.
REQ-037 Scenario 3, CONV2 wrap: at (H=7, D=15, W=0) the next issue is (H=0, D=0, W=1); after (7, 15, 89) come 8 bubbles, then CONV3 at (0, 0, 0).
REQ-038 Scenario 4, stall: Stall high for 3 cycles at CONV3 (H=5, D=2, W=10) -> 3 bubbles with H/D/W held, then (H=6, D=2, W=10); total Busy time grows by exactly 3.
REQ-039 Scenario 5, reset and Start during run: Start re-pulsed mid-run -> no effect; Rst_n low mid-MAXPOOL -> all outputs 0 asynchronously, no Done; a later Start restarts at CONV1 (0, 0, 0).
REQ-040 Scenario 6, FC2 end: the FC2 issues are W=0..4 with D=0, then 8 bubbles, then a single-cycle Done, then IDLE.
